data_ram_responder: RTL
=======================

Name: data_ram_responder

Overview:
- Bus-side responder for the RV32I core's data port: receives the core's load/store requests (busWe, funct3-coded strb) and services them from a word-organised on-chip RAM.
- Performs byte-lane merge on stores and sign/zero extension on loads.
- Programmable wait-state counter, with a one-cycle ready pulse per transaction.
- Sits between the datapath bus master and data memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 1, extra cycles between request capture and response (0..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- busReq  input  1  request valid; sampled only in IDLE
- busAddr  input  32  byte address
- busWe  input  1  1 = store, 0 = load
- strb  input  3  instr funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- busWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busRData  output  32  load result, extended to 32 bits; valid only while busReady=1
- busReady  output  1  one-cycle completion pulse
- busErr  output  1  asserted with busReady when the request was rejected

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: busReady=0, busErr=0, busRData=0, FSM in IDLE, wait counter 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE with busReq=1:
  - Capture addr, we, strb and wdata.
  - Compute error. If error, go to RESP. Otherwise load counter with WAIT_CYCLES and go to WAIT, or go to RESP directly if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next state is RESP.
- RESP:
  - busReady=1 for exactly one cycle, then return to IDLE.
  - busReq is ignored in RESP; the earliest next capture is the cycle after RESP.
- Latency: a request captured at edge N gives busReady=1 during cycle N+1+WAIT_CYCLES.
- Error conditions (any one sets busErr; no RAM write; busRData=0):
  - strb encoding 011, 110 or 111.
  - Store with strb 100 or 101.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - busAddr[31:ADDR_WIDTH+2] nonzero.
- Store:
  - Target word index = addr[ADDR_WIDTH+1:2].
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unselected lanes are preserved.
  - The write occurs on the edge that enters RESP; busRData=0 during a store response.
- Load:
  - The word is read on the edge entering RESP; the selected lane(s) are shifted to the LSBs.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - busRData is registered and returns to 0 when busReady falls.
- Master inputs may change after capture; only captured values are used.
- Reset asserted in WAIT or RESP: abort the transaction with no write and no ready pulse; return to IDLE on the next edge.
- Back-to-back requests: minimum issue interval is 2+WAIT_CYCLES cycles.
- A store followed by a load to the same word must return the stored data.

Test Plan:
- Reset, then with WAIT_CYCLES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> busReady 2 cycles after each capture; LW returns 0xDEADBEEF, busErr=0.
- After that word: SB addr 0x11 data 0x000000A5, then LW 0x10 -> 0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
- SH addr 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001, lower half unchanged.
- Errors, each response with busErr=1 and busRData=0, no write confirmed by readback:
  - LW 0x13
  - SH 0x21
  - strb=011
  - store with strb=100
  - addr 0x00001000 (ADDR_WIDTH=10)
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds -> ready exactly 1 and 4 cycles after capture; busReq held high through RESP produces no extra response.
- SW 0x30 0x12345678 accepted, reset pulsed in WAIT -> no busReady; a subsequent LW 0x30 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/data_ram_responder.sv
// Data-port responder for the RV32I core: word-organised RAM with byte-lane
// store merge, sign/zero-extended loads, programmable wait states and one-cycle ready.
//
//   state  | meaning
//   S_IDLE | waiting for busReq; captures the request and checks it
//   S_WAIT | counting down wait states before servicing
//   S_RESP | busReady/busErr/busRData presented for one cycle
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic [31:0] busAddr,
  input  logic        busWe,
  input  logic [2:0]  strb,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int AW = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [2:0]      strb_q;
  logic [31:0]     wdata_q;
  logic [3:0]      cnt_q;
  logic [31:0]     rdata_q;
  logic            ready_q;
  logic            err_q;

  logic [31:0]     mem [2**ADDR_WIDTH];

  logic            in_idle;
  logic            req_err;
  logic            commit;
  logic [AW-1:0]   act_addr;
  logic            act_we;
  logic [2:0]      act_strb;
  logic [31:0]     act_wdata;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rd_word;
  logic [31:0]     shifted;
  logic [31:0]     ld_data;

  assign in_idle = (state_q == S_IDLE);

  // With zero wait states the RAM is accessed on the capture edge itself,
  // so the live bus inputs are used instead of the captured copies.
  assign act_addr  = in_idle ? busAddr[AW-1:0] : addr_q;
  assign act_we    = in_idle ? busWe           : we_q;
  assign act_strb  = in_idle ? strb            : strb_q;
  assign act_wdata = in_idle ? busWData        : wdata_q;

  always_comb begin
    req_err = 1'b0;
    case (strb)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      default: ;
    endcase
    if (busWe && strb[2]) req_err = 1'b1;
    if ((strb[1:0] == 2'b01) && busAddr[0]) req_err = 1'b1;
    if ((strb[1:0] == 2'b10) && (busAddr[1:0] != 2'b00)) req_err = 1'b1;
    if ((busAddr >> AW) != 32'd0) req_err = 1'b1;
  end

  assign commit = !reset &&
                  ((in_idle && busReq && !req_err && (WAIT_CYCLES == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1)));

  always_comb begin
    be = 4'b0000;
    wd = act_wdata;
    case (act_strb[1:0])
      2'b00: begin
        be = 4'b0001 << act_addr[1:0];
        wd = {4{act_wdata[7:0]}};
      end
      2'b01: begin
        be = act_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{act_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rd_word = mem[act_addr[AW-1:2]];
  assign shifted = rd_word >> {act_addr[1:0], 3'b000};

  always_comb begin
    case (act_strb)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && act_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[act_addr[AW-1:2]][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= 3'b000;
      wdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          if (busReq) begin
            addr_q  <= busAddr[AW-1:0];
            we_q    <= busWe;
            strb_q  <= strb;
            wdata_q <= busWData;
            if (req_err) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              rdata_q <= busWe ? 32'd0 : ld_data;
            end else begin
              cnt_q   <= 4'(WAIT_CYCLES);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= we_q ? 32'd0 : ld_data;
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busRData = rdata_q;
  assign busReady = ready_q;
  assign busErr   = err_q;

endmodule
